// File: rtl/pixel_packet_framer.sv
// pixel_packet_framer
//   Frames a variable-length byte payload as
//     EA FF | PHL_ID dtype | dlen[15:8] dlen[7:0] | payload | [CRC lo, CRC hi] | AA DD | zero pad
//   and packs the stream PIX_BYTES bytes per pixel: stream byte k*PIX_BYTES+j lands in
//   pixel k, bits [j*8 +: 8]. One pixel is emitted per pix_en cycle while a packet is in flight.
//
//   Optional build macro: PKT_CRC_EN -- inserts a CRC-16-CCITT (poly 0x1021, init 0xFFFF,
//   MSB-first, no final XOR) over the payload bytes, low byte first, before the EOF bytes.
//
// Ports
//   tx_pixel_clk  in   pixel clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   data          in   payload, byte i = data[i*8 +: 8]
//   dlen          in   payload length in bytes
//   dtype         in   header data-type byte
//   pkt_valid     in   packet offered
//   pkt_ready     out  packet can be accepted
//   pix_en        in   pixel slot available this cycle
//   pixel_value   out  packed pixel (0 outside emission cycles)
//   pixel_valid   out  pixel_value carries a framed pixel
//   busy          out  packet in progress
//   pkt_done      out  pulse together with the last pixel of a packet
//   err_len       out  pulse when a packet is rejected for dlen > MAX_DLEN
//   fsm_state     out  current FSM state (0 = IDLE, 1 = SEND), for observation
//
// Handshake: a packet transfers on a rising edge where pkt_valid and pkt_ready are both 1;
// pkt_ready is only ever high in IDLE, and the accepted data/dlen/dtype are captured on that
// edge, so later input changes have no effect on the packet in flight.
module pixel_packet_framer #(
  parameter int         MAX_DLEN  = 64,
  parameter int         PIX_BYTES = 6,
  parameter int         OUT_W     = 64,
  parameter logic [7:0] PHL_ID    = 8'h00
) (
  input  logic                  tx_pixel_clk,
  input  logic                  rst_n,
  input  logic [MAX_DLEN*8-1:0] data,
  input  logic [15:0]           dlen,
  input  logic [7:0]            dtype,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic                  pix_en,
  output logic [OUT_W-1:0]      pixel_value,
  output logic                  pixel_valid,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  err_len,
  output logic [1:0]            fsm_state
);

`ifdef PKT_CRC_EN
  localparam logic [16:0] TRAILER = 17'd10;
`else
  localparam logic [16:0] TRAILER = 17'd8;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
  state_t state, state_next;

  logic [MAX_DLEN*8-1:0] data_q;
  logic [15:0]           dlen_q;
  logic [7:0]            dtype_q;
  logic [16:0]           idx_q;

  logic             accept, len_bad, emit, last_pix;
  logic [16:0]      pay_end, total_n;
  logic [16:0]      pos, off;
  logic [7:0]       byte_v;
  logic [OUT_W-1:0] packed_pix;

  logic [OUT_W-1:0] pixel_value_d;
  logic             pixel_valid_d, busy_d, pkt_done_d, err_len_d, ready_d;

`ifdef PKT_CRC_EN
  logic [15:0] crc_q, crc_run;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign accept   = pkt_valid & pkt_ready & (state == IDLE);
  assign len_bad  = {16'd0, dlen} > MAX_DLEN[31:0];
  assign emit     = (state == SEND) & pix_en;
  assign pay_end  = 17'd6 + {1'b0, dlen_q};
  assign total_n  = {1'b0, dlen_q} + TRAILER;
  // Last pixel once this pixel covers stream byte N-1.
  assign last_pix = (idx_q + 17'(PIX_BYTES)) >= total_n;
  assign fsm_state = state;

  // Build the pixel at byte index idx_q. Every lane decodes its own stream position,
  // so header/payload/EOF boundaries may fall anywhere inside a pixel. The CRC is
  // advanced lane by lane in stream order, so CRC lanes always see the full payload
  // CRC even when the last payload bytes share the pixel.
  always_comb begin
    packed_pix = '0;
    pos        = '0;
    off        = '0;
    byte_v     = '0;
`ifdef PKT_CRC_EN
    crc_run    = crc_q;
`endif
    for (int j = 0; j < PIX_BYTES; j++) begin
      pos    = idx_q + 17'(j);
      off    = pos - 17'd6;
      byte_v = 8'h00;
      if (pos == 17'd0)      byte_v = 8'hEA;
      else if (pos == 17'd1) byte_v = 8'hFF;
      else if (pos == 17'd2) byte_v = PHL_ID;
      else if (pos == 17'd3) byte_v = dtype_q;
      else if (pos == 17'd4) byte_v = dlen_q[15:8];
      else if (pos == 17'd5) byte_v = dlen_q[7:0];
      else if (pos < pay_end) begin
        for (int i = 0; i < MAX_DLEN; i++) begin
          if (off == 17'(i)) byte_v = data_q[i*8 +: 8];
        end
`ifdef PKT_CRC_EN
        crc_run = crc_step(crc_run, byte_v);
`endif
      end
`ifdef PKT_CRC_EN
      else if (pos == pay_end)          byte_v = crc_run[7:0];
      else if (pos == pay_end + 17'd1)  byte_v = crc_run[15:8];
      else if (pos == pay_end + 17'd2)  byte_v = 8'hAA;
      else if (pos == pay_end + 17'd3)  byte_v = 8'hDD;
`else
      else if (pos == pay_end)          byte_v = 8'hAA;
      else if (pos == pay_end + 17'd1)  byte_v = 8'hDD;
`endif
      packed_pix[j*8 +: 8] = byte_v;
    end
  end

  // FSM: state register
  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !len_bad) state_next = SEND;
      SEND:    if (emit && last_pix)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs (registered below, giving the one-cycle pix_en -> pixel latency)
  always_comb begin
    pixel_value_d = '0;
    pixel_valid_d = 1'b0;
    pkt_done_d    = 1'b0;
    err_len_d     = accept & len_bad;
    busy_d        = (state_next == SEND);
    // Ready returns one cycle after the done pixel, and drops on the accept edge.
    ready_d       = (state == IDLE) && (state_next == IDLE);
    if (emit) begin
      pixel_value_d = packed_pix;
      pixel_valid_d = 1'b1;
      pkt_done_d    = last_pix;
    end
  end

  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_value <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      err_len     <= 1'b0;
      pkt_ready   <= 1'b0;
    end else begin
      pixel_value <= pixel_value_d;
      pixel_valid <= pixel_valid_d;
      busy        <= busy_d;
      pkt_done    <= pkt_done_d;
      err_len     <= err_len_d;
      pkt_ready   <= ready_d;
    end
  end

  // Packet capture and progress
  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      dlen_q  <= '0;
      dtype_q <= '0;
      idx_q   <= '0;
`ifdef PKT_CRC_EN
      crc_q   <= 16'hFFFF;
`endif
    end else if (accept) begin
      data_q  <= data;
      dlen_q  <= dlen;
      dtype_q <= dtype;
      idx_q   <= '0;
`ifdef PKT_CRC_EN
      crc_q   <= 16'hFFFF;
`endif
    end else if (emit) begin
      idx_q   <= idx_q + 17'(PIX_BYTES);
`ifdef PKT_CRC_EN
      crc_q   <= crc_run;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_packet_framer.sv
// Directed testbench for pixel_packet_framer (default parameters: MAX_DLEN=64,
// PIX_BYTES=6, OUT_W=64, PHL_ID=00). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_pixel_packet_framer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] data = '0;
  logic [15:0]  dlen = '0;
  logic [7:0]   dtype = '0;
  logic         pkt_valid = 1'b0;
  logic         pix_en = 1'b0;
  logic         pkt_ready;
  logic [63:0]  pixel_value;
  logic         pixel_valid;
  logic         busy;
  logic         pkt_done;
  logic         err_len;
  logic [1:0]   fsm_state;

  int vectors = 0;
  int miscompares = 0;

  // Captured by run_pkt
  logic [63:0] got[$];
  int          done_idx, n_done, busy_hi, gap_err, gap_cycles, extra_valid;
  logic        ready_after, ready_at_done, timed_out;

  pixel_packet_framer dut (
    .tx_pixel_clk(clk),
    .rst_n(rst_n),
    .data(data),
    .dlen(dlen),
    .dtype(dtype),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pix_en(pix_en),
    .pixel_value(pixel_value),
    .pixel_valid(pixel_valid),
    .busy(busy),
    .pkt_done(pkt_done),
    .err_len(err_len),
    .fsm_state(fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: offer one packet; returns at the falling edge after the accept edge,
  // with the packet inputs scrambled so later changes must not matter.
  task automatic offer(input logic [15:0] len, input logic [7:0] dt, input logic [127:0] pl);
    int w;
    w = 0;
    while (pkt_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (w >= 20) begin
      miscompares++;
      $display("FAIL offer_ready_wait: pkt_ready=%b required 1 within 20 cycles", pkt_ready);
    end
    data      = '0;
    data[127:0] = pl;
    dlen      = len;
    dtype     = dt;
    pkt_valid = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
    dlen      = 16'($urandom());
    dtype     = 8'($urandom());
    for (int i = 0; i < 16; i++) data[i*32 +: 32] = $urandom();
  endtask

  // Driver: supply pix_en from pat (LSB first, then 1s) until pkt_done, then two more cycles.
  task automatic run_pkt(input logic [7:0] pat, input int pat_len);
    int  c;
    bit  fin;
    got.delete();
    done_idx = -1; n_done = 0; gap_err = 0; gap_cycles = 0; extra_valid = 0;
    busy_hi = (busy === 1'b1) ? 1 : 0;
    ready_at_done = 1'bx;
    c = 0;
    fin = 1'b0;
    while (!fin && c < 40) begin
      pix_en = (c < pat_len) ? pat[c] : 1'b1;
      @(negedge clk);
      c++;
      if (busy === 1'b1) busy_hi++;
      if (pixel_valid === 1'b1) got.push_back(pixel_value);
      else begin
        gap_cycles++;
        if (pixel_value !== 64'h0) gap_err++;
      end
      if (pkt_done === 1'b1) begin
        n_done++;
        done_idx = got.size() - 1;
        ready_at_done = pkt_ready;
        fin = 1'b1;
      end
    end
    timed_out = !fin;
    pix_en = 1'b1;
    @(negedge clk);
    ready_after = pkt_ready;
    if (pixel_valid === 1'b1) extra_valid++;
    @(negedge clk);
    if (pixel_valid === 1'b1) extra_valid++;
    pix_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pkt_ready, pixel_valid, busy, pkt_done, err_len} !== 5'b0 || pixel_value !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready/valid/busy/done/err=%b value=%h required 00000 and 0",
               {pkt_ready, pixel_valid, busy, pkt_done, err_len}, pixel_value);
    end
    vectors++;
    if (fsm_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d required 0", fsm_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (pkt_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", pkt_ready, busy);
    end
  endtask

`ifndef PKT_CRC_EN
  task automatic test_basic();
    logic [63:0] exp[2];
    exp[0] = 64'h0000_0400_0100_FFEA;
    exp[1] = 64'h0000_DDAA_4433_2211;
    offer(16'd4, 8'h01, 128'h4433_2211);
    vectors++;
    if (busy !== 1'b1 || pkt_ready !== 1'b0 || fsm_state !== 2'd1) begin
      miscompares++;
      $display("FAIL basic_accept: busy=%b ready=%b state=%0d required 1 0 1", busy, pkt_ready, fsm_state);
    end
    run_pkt(8'h00, 0);
    vectors++;
    if (timed_out !== 1'b0 || got.size() !== 2) begin
      miscompares++;
      $display("FAIL basic_count: timeout=%b pixels=%0d required 0 2", timed_out, got.size());
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (((got.size() > i) ? got[i] : 64'hx) !== exp[i]) begin
        miscompares++;
        $display("FAIL basic_pixel%0d: got %h required %h", i, (got.size() > i) ? got[i] : 64'hx, exp[i]);
      end
    end
    vectors++;
    if (done_idx !== 1 || n_done !== 1 || ready_at_done !== 1'b0 || ready_after !== 1'b1 || extra_valid !== 0) begin
      miscompares++;
      $display("FAIL basic_done: done_idx=%0d n_done=%0d ready_at_done=%b ready_after=%b extra=%0d required 1 1 0 1 0",
               done_idx, n_done, ready_at_done, ready_after, extra_valid);
    end
  endtask

  // dlen=5 with a given pix_en pattern; the pixels must not depend on the pattern.
  task automatic test_remainder(input logic [7:0] pat, input int pat_len, input int exp_gaps);
    logic [63:0] exp[3];
    exp[0] = 64'h0000_0500_0100_FFEA;
    exp[1] = 64'h0000_AA55_4433_2211;
    exp[2] = 64'h0000_0000_0000_00DD;
    offer(16'd5, 8'h01, 128'h55_4433_2211);
    run_pkt(pat, pat_len);
    vectors++;
    if (timed_out !== 1'b0 || got.size() !== 3 || extra_valid !== 0) begin
      miscompares++;
      $display("FAIL rem_count: timeout=%b pixels=%0d extra=%0d required 0 3 0", timed_out, got.size(), extra_valid);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (((got.size() > i) ? got[i] : 64'hx) !== exp[i]) begin
        miscompares++;
        $display("FAIL rem_pixel%0d: got %h required %h", i, (got.size() > i) ? got[i] : 64'hx, exp[i]);
      end
    end
    vectors++;
    if (gap_cycles !== exp_gaps || gap_err !== 0 || done_idx !== 2) begin
      miscompares++;
      $display("FAIL rem_gaps: gaps=%0d nonzero_gap_values=%0d done_idx=%0d required %0d 0 2",
               gap_cycles, gap_err, done_idx, exp_gaps);
    end
  endtask

  task automatic test_zero_len();
    logic [63:0] exp[2];
    exp[0] = 64'h0000_0000_0100_FFEA;
    exp[1] = 64'h0000_0000_0000_DDAA;
    offer(16'd0, 8'h01, 128'h0);
    run_pkt(8'h00, 0);
    vectors++;
    if (timed_out !== 1'b0 || got.size() !== 2) begin
      miscompares++;
      $display("FAIL zero_count: timeout=%b pixels=%0d required 0 2", timed_out, got.size());
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (((got.size() > i) ? got[i] : 64'hx) !== exp[i]) begin
        miscompares++;
        $display("FAIL zero_pixel%0d: got %h required %h", i, (got.size() > i) ? got[i] : 64'hx, exp[i]);
      end
    end
    vectors++;
    if (busy_hi !== 2) begin
      miscompares++;
      $display("FAIL zero_busy: busy cycles=%0d required 2", busy_hi);
    end
  endtask

  task automatic test_len_err();
    int n_err, n_valid, n_busy;
    offer(16'd65, 8'h01, 128'h1234);
    n_err   = (err_len === 1'b1) ? 1 : 0;
    n_valid = 0;
    n_busy  = (busy === 1'b1) ? 1 : 0;
    pix_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (err_len === 1'b1)     n_err++;
      if (pixel_valid === 1'b1) n_valid++;
      if (busy === 1'b1)        n_busy++;
    end
    pix_en = 1'b0;
    vectors++;
    if (n_err !== 1 || n_valid !== 0 || n_busy !== 0) begin
      miscompares++;
      $display("FAIL len_err: err pulses=%0d valid=%0d busy=%0d required 1 0 0", n_err, n_valid, n_busy);
    end
    vectors++;
    if (pkt_ready !== 1'b1 || fsm_state !== 2'd0) begin
      miscompares++;
      $display("FAIL len_err_idle: ready=%b state=%0d required 1 0", pkt_ready, fsm_state);
    end
    test_basic();
  endtask

  task automatic test_mid_reset();
    int w;
    offer(16'd5, 8'h01, 128'h55_4433_2211);
    pix_en = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (pixel_valid !== 1'b1 && w < 10);
    vectors++;
    if (pixel_valid !== 1'b1 || pixel_value !== 64'h0000_0500_0100_FFEA) begin
      miscompares++;
      $display("FAIL mid_reset_pixel0: valid=%b value=%h required 1 00000500_0100ffea", pixel_valid, pixel_value);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pkt_ready, pixel_valid, busy, pkt_done, err_len} !== 5'b0 || pixel_value !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: ready/valid/busy/done/err=%b value=%h required 00000 and 0",
               {pkt_ready, pixel_valid, busy, pkt_done, err_len}, pixel_value);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (pkt_ready !== 1'b1 || pixel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_release: ready=%b valid=%b required 1 0", pkt_ready, pixel_valid);
    end
    @(negedge clk);
    vectors++;
    if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_partial: valid=%b busy=%b required 0 0", pixel_valid, busy);
    end
    pix_en = 1'b0;
    test_basic();
  endtask
`else
  task automatic test_crc();
    logic [63:0] exp[4];
    exp[0] = 64'h0000_0900_0100_FFEA;
    exp[1] = 64'h0000_3635_3433_3231;
    exp[2] = 64'h0000_AA29_B139_3837;
    exp[3] = 64'h0000_0000_0000_00DD;
    offer(16'd9, 8'h01, 128'h39_3837_3635_3433_3231);
    run_pkt(8'h00, 0);
    vectors++;
    if (timed_out !== 1'b0 || got.size() !== 4 || done_idx !== 3) begin
      miscompares++;
      $display("FAIL crc_count: timeout=%b pixels=%0d done_idx=%0d required 0 4 3", timed_out, got.size(), done_idx);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (((got.size() > i) ? got[i] : 64'hx) !== exp[i]) begin
        miscompares++;
        $display("FAIL crc_pixel%0d: got %h required %h", i, (got.size() > i) ? got[i] : 64'hx, exp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef PKT_CRC_EN
    test_basic();
    test_remainder(8'h00, 0, 0);
    test_zero_len();
    test_len_err();
    test_remainder(8'b0000_1001, 4, 2);
    test_mid_reset();
`else
    test_crc();
    test_crc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_packet_framer.md
Name: pixel_packet_framer

Overview:
- Parametrised successor to the fixed-length MIPI pixel data generator.
- Frames a variable-length byte payload into a SOF/header/payload/EOF byte stream and packs it into pixel words, PIX_BYTES bytes per pixel.
- Sits between the miner result/command logic and the MIPI TX pixel interface.
- Adds a valid/ready packet handshake, runtime length, pixel-slot pacing, length error reporting and generic remainder handling.

Parameters:
- MAX_DLEN, 64: maximum payload bytes; sizes the data port.
- PIX_BYTES, 6: bytes packed per pixel, 1..8.
- OUT_W, 64: pixel_value width; must be >= PIX_BYTES*8. Unused upper bits are 0.
- PHL_ID, 8'h00: header ID byte.

Ports:
- tx_pixel_clk, in, 1: pixel clock; all logic on its rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- data, in, MAX_DLEN*8: payload; byte i = data[i*8 +: 8].
- dlen, in, 16: payload length in bytes for this packet.
- dtype, in, 8: header data-type byte.
- pkt_valid, in, 1: packet offered.
- pkt_ready, out, 1: block can accept a packet.
- pix_en, in, 1: a pixel slot is available this cycle.
- pixel_value, out, OUT_W: packed pixel.
- pixel_valid, out, 1: pixel_value carries a framed pixel.
- busy, out, 1: packet in progress.
- pkt_done, out, 1: one-cycle pulse with the last pixel.
- err_len, out, 1: one-cycle pulse when a packet is rejected.

Behaviour:
- Reset values (asynchronous, rst_n=0): state IDLE, pkt_ready=0 during reset (1 after release), pixel_value=0, pixel_valid=0, busy=0, pkt_done=0, err_len=0, byte index=0.
- Byte stream, in order:
  - 0xEA, 0xFF (SOF)
  - PHL_ID, dtype
  - dlen[15:8], dlen[7:0]
  - payload bytes 0..dlen-1
  - 0xAA, 0xDD (EOF)
  - zero padding to fill the final pixel
- Total bytes N = dlen+8. Pixel count P = ceil(N/PIX_BYTES).
- Packing: stream byte k*PIX_BYTES+j goes to pixel k, bits [j*8 +: 8].
- EOF and header bytes may straddle pixels. Every remainder, including 0 and PIX_BYTES-1, is handled generically.
- IDLE state:
  - pkt_ready=1.
  - On pkt_valid & pkt_ready, data, dlen and dtype are registered.
  - If dlen > MAX_DLEN: err_len pulses next cycle and the block stays in IDLE with no pixels.
  - Otherwise: go to SEND, busy=1, pkt_ready=0.
- SEND state:
  - Each cycle with pix_en=1, one pixel is emitted: pixel_value and pixel_valid=1 are registered and appear the cycle after pix_en (1-cycle latency). Byte index advances by PIX_BYTES.
  - pix_en=0: no emission; pixel_valid=0; pixel_value=0; progress is held.
  - On emission of pixel P-1: pkt_done=1 in the same output cycle, busy drops in that same cycle, state returns to IDLE, pkt_ready=1 the following cycle.
- Outside emission cycles: pixel_value=0, pixel_valid=0.
- pkt_valid is ignored while busy. The registered packet is immune to input changes after acceptance.
- dlen=0 is legal: header followed by EOF.
- Reset mid-packet aborts immediately. No partial pixel is output after rst_n deasserts.
- Arithmetic:
  - Byte index is 17 bits and never wraps within a legal packet.
  - Payload byte reads beyond dlen yield EOF/pad per stream position, never data bytes.

Optional Feature:
- Macro: PKT_CRC_EN.
- Defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final XOR) is computed over the payload bytes only.
  - It is inserted after the payload and before EOF, low byte first. N = dlen+10.
  - The CRC is computed serially, PIX_BYTES bytes per emitted pixel (unrolled), and is complete before its bytes are emitted.
- Undefined: no CRC logic; N = dlen+8.

Test Plan:
- PIX_BYTES=6, dlen=4, dtype=01, payload 11 22 33 44:
  - pixel0 = 64'h0000_0400_0100_FFEA
  - pixel1 = 64'h0000_DDAA_4433_2211
  - pkt_done with pixel1; pkt_ready high again on the next cycle.
- dlen=5, payload 11..55:
  - pixel1 = 64'h0000_AA55_4433_2211
  - pixel2 = 64'h0000_0000_0000_00DD
  - exactly 3 pixel_valid pulses.
- dlen=0:
  - pixel1 = 64'h0000_0000_0000_DDAA
  - busy high for exactly the 2 emitting slots.
- dlen=MAX_DLEN+1 offered:
  - err_len pulses once; no pixel_valid; busy stays 0; the next legal packet is framed correctly.
- pix_en toggled 1,0,0,1 during the dlen=5 packet:
  - pixels are identical to the gap-free case; pixel_valid=0 and pixel_value=0 in gap cycles.
- rst_n pulsed low after pixel0 of a 3-pixel packet:
  - all outputs are 0 immediately; after release, pkt_ready=1; a new packet starts with 0xFFEA in pixel0.
- With PKT_CRC_EN, payload "123456789" (9 bytes):
  - CRC bytes B1 29 precede AA DD in the stream.
